// File: rtl/alu_pkg.sv
// Shared types and helpers for the operand entry front end of the 6-bit signed ALU.
package alu_pkg;

  localparam int OPW = 6;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } load_state_t;

  // Sign + magnitude to two's complement; a negative zero collapses to 0.
  function automatic logic [OPW-1:0] to_twos(input logic sign, input logic [OPW-1:0] mag);
    logic [OPW-1:0] neg;
    neg = ~mag + {{(OPW-1){1'b0}}, 1'b1};
    if (sign && (mag != '0)) return neg;
    return mag;
  endfunction

  // Negative entries may reach one step further than positive ones (-2^(OPW-1)).
  function automatic logic entry_legal(input logic sign, input logic [OPW-1:0] mag);
    logic [OPW-1:0] half;
    half = {1'b1, {(OPW-1){1'b0}}};
    if (sign) return (mag <= half);
    return (mag < half);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter, and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level held long enough: accept it; only a rise is reported.
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_loader.sv
// Captures operands A then B from sign/magnitude switches on debounced load
// presses, range-checks them and holds the two's-complement values.
module operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH     = OPW,
  parameter int DB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mag_sw,
  input  logic             sign_sw,
  input  logic             load_btn,
  input  logic             clear_btn,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             operands_valid,
  output logic             entry_err,
  output logic [1:0]       stage,
  output logic             nA_LED,
  output logic             nB_LED
);

  logic             load_p;
  logic             clear_p;
  logic [WIDTH-1:0] value;
  logic             legal;
  load_state_t      state;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
    .clk   (clk),
    .reset (reset),
    .btn   (load_btn),
    .press (load_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
    .clk   (clk),
    .reset (reset),
    .btn   (clear_btn),
    .press (clear_p)
  );

  // Switches are only looked at in the cycle a load pulse is present.
  assign value = to_twos(sign_sw, mag_sw);
  assign legal = entry_legal(sign_sw, mag_sw);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_A;
      A              <= '0;
      B              <= '0;
      operands_valid <= 1'b0;
      entry_err      <= 1'b0;
    end else if (clear_p) begin
      // Clear takes priority over a coincident load.
      state          <= S_A;
      A              <= '0;
      B              <= '0;
      operands_valid <= 1'b0;
      entry_err      <= 1'b0;
    end else if (load_p) begin
      if (!legal) begin
        entry_err <= 1'b1;
      end else begin
        entry_err <= 1'b0;
        case (state)
          S_A: begin
            A     <= value;
            state <= S_B;
          end
          S_B: begin
            B              <= value;
            operands_valid <= 1'b1;
            state          <= S_DONE;
          end
          S_DONE: begin
            A              <= value;
            operands_valid <= 1'b0;
            state          <= S_B;
          end
          default: state <= S_A;
        endcase
      end
    end
  end

  assign stage  = state;
  assign nA_LED = A[WIDTH-1];
  assign nB_LED = B[WIDTH-1];

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Front end for the 6-bit signed ALU datapath: captures operands A then B from board switches as sign + magnitude, converts each to 6-bit two's complement and holds them stable for the compare/arithmetic units.
- Handles the user-input side: push-button synchronisation and debounce, an entry-sequencing FSM, range checking, and negative-indicator LEDs driven from the stored operands.

Parameters:
- WIDTH, 6, operand width in bits (two's complement); the magnitude switch bus is also WIDTH bits.
- DB_CYCLES, 250000, consecutive stable cycles needed to accept a button level change; benches override to 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- mag_sw  in  WIDTH  unsigned magnitude from switches; asynchronous to clk and used only at a capture event.
- sign_sw  in  1  1 = negative entry.
- load_btn  in  1  raw, asynchronous push-button: capture the current entry.
- clear_btn  in  1  raw, asynchronous push-button: discard both operands.
- A  out  WIDTH  stored operand A, two's complement.
- B  out  WIDTH  stored operand B, two's complement.
- operands_valid  out  1  high while A and B are both captured (state S_DONE).
- entry_err  out  1  the last load attempt was out of range.
- stage  out  2  0 = awaiting A, 1 = awaiting B, 2 = done (LED display).
- nA_LED  out  1  equals A[WIDTH-1].
- nB_LED  out  1  equals B[WIDTH-1].

Behaviour:
- Reset, synchronous: A=0, B=0, operands_valid=0, entry_err=0, stage=0, nA_LED=0, nB_LED=0. Synchronisers, debounce counters and debounced levels are all cleared to 0. Reset mid-debounce or mid-sequence discards everything and returns to S_A.
- Button path, per button:
  - 2-flop synchroniser.
  - Debounce: the counter increments while the synced level differs from the debounced level, and zeroes when they match. When the counter reaches DB_CYCLES-1 with the levels still differing, the debounced level flips and the counter zeroes.
  - Press event: one-cycle pulse on the debounced rising edge only. Release produces no event; a held button gives exactly one pulse.
- Latency: a clean load_btn rise sampled at edge t produces its pulse after edge t+1+DB_CYCLES. Registered outputs update on the following edge, t+2+DB_CYCLES.
- Conversion: if sign_sw=1 and mag_sw!=0, value = (~mag_sw + 1) truncated to WIDTH; otherwise value = mag_sw. Negative zero is stored as 0.
- Range check, for WIDTH=6:
  - Positive entries are legal for mag_sw 0..31.
  - Negative entries are legal for mag_sw 0..32; -32 is stored as 6'b100000.
  - Anything else is illegal.
- FSM states: S_A (stage 0), S_B (stage 1), S_DONE (stage 2).
  - S_A + legal load: A<=value, entry_err<=0, go to S_B.
  - S_B + legal load: B<=value, entry_err<=0, go to S_DONE, operands_valid<=1.
  - S_DONE + legal load: A<=value, B is kept, operands_valid<=0, go to S_B (start of a new pair).
  - Illegal load in any state: entry_err<=1; state, A, B and operands_valid are unchanged.
  - Clear pulse in any state: A<=0, B<=0, entry_err<=0, operands_valid<=0, go to S_A.
- Simultaneous clear and load pulses in the same cycle: clear wins and the load is dropped.
- Switches are sampled only in the capture cycle; switch changes at other times have no effect.
- nA_LED and nB_LED come combinationally from the A and B registers, so they are glitch-free.

Decomposition:
- alu_pkg holds:
  - localparam OPW = 6;
  - typedef enum logic [1:0] {S_A=0, S_B=1, S_DONE=2} load_state_t;
  - function to_twos(sign, mag) returning the converted value;
  - function entry_legal(sign, mag).
- One sub-module, btn_debounce (synchroniser + counter + rising-edge pulse, parameter DB_CYCLES), instantiated for load_btn and for clear_btn.

Test Plan:
All scenarios run with DB_CYCLES=4.
- Reset, then mag=5, sign=0, press load, then mag=3, sign=1, press load: A=6'h05, B=6'h3D, operands_valid=1, stage=2, nA_LED=0, nB_LED=1. The A update lands exactly DB_CYCLES+2 edges after the first sampled-high cycle.
- Bounce: toggle load_btn every 2 cycles for 20 cycles, then hold high: exactly one capture. Holding high for 100 cycles produces no further capture.
- Range: mag=32, sign=1 → A=6'h20, entry_err=0. In S_B, mag=32, sign=0 → entry_err=1, stage stays 1, B stays 0. Then mag=0, sign=1 → B=0, entry_err=0, operands_valid=1.
- From S_DONE (A=5, B=-3), load mag=7, sign=0 → A=6'h07, B still 6'h3D, operands_valid=0, stage=1.
- Drive load_btn and clear_btn high on the same cycle → clear wins: A=B=0, stage=0, entry_err=0, with no capture.
- Assert reset midway through a debounce count while in S_B → all outputs 0 and stage=0 on the next edge; the pending press produces no capture.
